// File: rtl/datamover_job_queue.sv
// datamover_job_queue: descriptor FIFO plus a small issue/wait/complete FSM
// that feeds copy jobs to the datamover one at a time and returns tagged
// completions over a valid/ready port.
// Optional watchdog: define DATAMOVER_JOBQ_TIMEOUT_EN to enable the WAIT
// timeout (completion flagged with cpl_err_o); otherwise WAIT never times out.
module datamover_job_queue #(
    parameter int QUEUE_DEPTH    = 4,
    parameter int AW             = 32,
    parameter int LW             = 32,
    parameter int ID_W           = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             clear_i,
    input  logic                             job_valid_i,
    output logic                             job_ready_o,
    input  logic [AW-1:0]                    job_src_i,
    input  logic [AW-1:0]                    job_dst_i,
    input  logic [LW-1:0]                    job_len_i,
    input  logic [ID_W-1:0]                  job_id_i,
    output logic                             dm_start_o,
    output logic [AW-1:0]                    dm_src_o,
    output logic [AW-1:0]                    dm_dst_o,
    output logic [LW-1:0]                    dm_len_o,
    input  logic                             dm_done_i,
    output logic                             cpl_valid_o,
    input  logic                             cpl_ready_i,
    output logic [ID_W-1:0]                  cpl_id_o,
    output logic                             cpl_err_o,
    output logic                             busy_o,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] occupancy_o
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int E_W   = 2 * AW + LW + ID_W;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] CPL   = 2'd3;

    logic [E_W-1:0]   mem [QUEUE_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    logic [AW-1:0]    head_src;
    logic [AW-1:0]    head_dst;
    logic [LW-1:0]    head_len;
    logic [ID_W-1:0]  head_id;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [ID_W-1:0]  id_q;
    logic             timeout_hit;

    // Full is decided from the stored count only, so a pop in the same cycle
    // never opens the push port early.
    assign full  = (count == CNT_W'(QUEUE_DEPTH));
    assign empty = (count == '0);
    assign push  = job_valid_i & ~full;
    assign pop   = (state == IDLE) & ~empty;

    assign {head_src, head_dst, head_len, head_id} = mem[rd_ptr];

    // Descriptor storage write port.
    // NOTE: the storage array has no reset; an entry is only read after it has
    // been written, because the occupancy count gates every pop.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {job_src_i, job_dst_i, job_len_i, job_id_i};
        end
    end

    // FIFO pointers and occupancy; clear flushes everything.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Next-state decode: pop in IDLE, pulse in ISSUE, wait for done, hold CPL.
    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!empty) state_nxt = (head_len != '0) ? ISSUE : CPL;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (dm_done_i || timeout_hit) state_nxt = CPL;
            CPL:     if (cpl_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state and the in-flight job registers loaded on each pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            dm_src_o <= '0;
            dm_dst_o <= '0;
            dm_len_o <= '0;
            id_q     <= '0;
        end else if (clear_i) begin
            state    <= IDLE;
            dm_src_o <= '0;
            dm_dst_o <= '0;
            dm_len_o <= '0;
            id_q     <= '0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                dm_src_o <= head_src;
                dm_dst_o <= head_dst;
                dm_len_o <= head_len;
                id_q     <= head_id;
            end
        end
    end

`ifdef DATAMOVER_JOBQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_cnt;
    logic            err_q;

    // A done arriving in the timeout cycle still counts as success.
    assign timeout_hit = (state == WAIT) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: restarts while in ISSUE (entry to WAIT), counts WAIT cycles,
    // and records whether the job left WAIT by timeout rather than done.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else if (clear_i) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == ISSUE)     wd_cnt <= '0;
            else if (state == WAIT) wd_cnt <= wd_cnt + 1'b1;

            if (pop)                                        err_q <= 1'b0;
            else if (state == WAIT && (dm_done_i || timeout_hit)) err_q <= ~dm_done_i;
        end
    end

    assign cpl_err_o = err_q;
`else
    assign timeout_hit = 1'b0;
    assign cpl_err_o   = 1'b0;
`endif

    assign job_ready_o = ~full;
    assign dm_start_o  = (state == ISSUE);
    assign cpl_valid_o = (state == CPL);
    assign cpl_id_o    = id_q;
    assign busy_o      = (state != IDLE) | ~empty;
    assign occupancy_o = count;

endmodule

// File: tb/tb_datamover_job_queue.sv
// Self-checking bench for datamover_job_queue: directed scenarios plus a
// randomized phase, all scored by an order-based model of issued jobs and
// completions (every accepted job starts once in push order unless its length
// is zero, and completes once in push order).
module tb_datamover_job_queue;

    localparam int QD = 4;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] len;
        logic [3:0]  id;
    } job_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [31:0] job_src = '0;
    logic [31:0] job_dst = '0;
    logic [31:0] job_len = '0;
    logic [3:0]  job_id = '0;
    logic        dm_start;
    logic [31:0] dm_src;
    logic [31:0] dm_dst;
    logic [31:0] dm_len;
    logic        dm_done = 1'b0;
    logic        cpl_valid;
    logic        cpl_ready = 1'b0;
    logic [3:0]  cpl_id;
    logic        cpl_err;
    logic        busy;
    logic [2:0]  occupancy;

    int n_checks = 0;
    int n_errors = 0;
    int start_cnt = 0;
    int cpl_cnt = 0;
    bit auto_done = 1'b0;
    bit spur_en = 1'b0;
    bit exp_err = 1'b0;

    job_t issue_q[$];
    job_t cpl_q[$];

    datamover_job_queue #(
        .QUEUE_DEPTH(QD), .AW(32), .LW(32), .ID_W(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .job_valid_i(job_valid), .job_ready_o(job_ready),
        .job_src_i(job_src), .job_dst_i(job_dst), .job_len_i(job_len), .job_id_i(job_id),
        .dm_start_o(dm_start), .dm_src_o(dm_src), .dm_dst_o(dm_dst), .dm_len_o(dm_len),
        .dm_done_i(dm_done),
        .cpl_valid_o(cpl_valid), .cpl_ready_i(cpl_ready), .cpl_id_o(cpl_id), .cpl_err_o(cpl_err),
        .busy_o(busy), .occupancy_o(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                        input logic [3:0] id);
        job_valid = 1'b1;
        job_src = s;
        job_dst = d;
        job_len = l;
        job_id = id;
        step();
        job_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag, input int budget);
        int n = 0;
        while (!dm_start && n < budget) begin
            step();
            n++;
        end
        check(tag, dm_start, 1'b1);
    endtask

    task automatic wait_cpl(input string tag, input int budget);
        int n = 0;
        while (!cpl_valid && n < budget) begin
            step();
            n++;
        end
        check(tag, cpl_valid, 1'b1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((busy || cpl_valid) && n < budget) begin
            step();
            n++;
        end
        check(tag, busy | cpl_valid, 1'b0);
    endtask

    // Scoreboard: observes the DUT at the falling edge, between active edges.
    initial forever begin
        job_t j;
        bit hold_pending = 1'b0;
        bit prev_start = 1'b0;
        logic [3:0] hold_id = '0;
        @(negedge clk);
        if (rst_n) begin
            if (clear) begin
                issue_q.delete();
                cpl_q.delete();
                hold_pending = 1'b0;
                prev_start = 1'b0;
            end else begin
                if (hold_pending) begin
                    check("cpl_hold_valid", cpl_valid, 1'b1);
                    check("cpl_hold_id", cpl_id, hold_id);
                end
                if (dm_start) begin
                    start_cnt++;
                    check("start_width", prev_start, 1'b0);
                    check("start_pending", issue_q.size() != 0, 1'b1);
                    if (issue_q.size() != 0) begin
                        j = issue_q.pop_front();
                        check("start_src", dm_src, j.src);
                        check("start_dst", dm_dst, j.dst);
                        check("start_len", dm_len, j.len);
                    end
                end
                if (cpl_valid && cpl_ready) begin
                    cpl_cnt++;
                    check("cpl_pending", cpl_q.size() != 0, 1'b1);
                    if (cpl_q.size() != 0) begin
                        j = cpl_q.pop_front();
                        check("cpl_id", cpl_id, j.id);
                        check("cpl_err", cpl_err, exp_err);
                    end
                end
                hold_pending = cpl_valid && !cpl_ready;
                hold_id = cpl_id;
                prev_start = dm_start;
                if (job_valid && job_ready) begin
                    j = '{src: job_src, dst: job_dst, len: job_len, id: job_id};
                    if (job_len != 0) issue_q.push_back(j);
                    cpl_q.push_back(j);
                end
            end
        end
    end

    // Datamover stand-in: answers each start with done after 1-5 WAIT cycles,
    // and optionally fires spurious done pulses while the queue is idle.
    initial forever begin
        @(negedge clk);
        if (auto_done && dm_start) begin
            repeat ($urandom_range(1, 5)) @(posedge clk);
            #1 dm_done = 1'b1;
            @(posedge clk);
            #1 dm_done = 1'b0;
        end else if (auto_done && spur_en && !busy && $urandom_range(0, 15) == 0) begin
            @(posedge clk);
            #1 dm_done = 1'b1;
            @(posedge clk);
            #1 dm_done = 1'b0;
        end
    end

    initial begin
        int s0;
        int c0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset values.
        check("rst_ready", job_ready, 1'b1);
        check("rst_start", dm_start, 1'b0);
        check("rst_cpl_valid", cpl_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_occ", occupancy, 3'd0);
        check("rst_src", dm_src, 32'h0);
        check("rst_cpl_id", cpl_id, 4'h0);
        check("rst_cpl_err", cpl_err, 1'b0);

        // Single job: start exactly two cycles after the push.
        push(32'h1000, 32'h2000, 32'd64, 4'd3);
        check("t1_occ", occupancy, 3'd1);
        check("t1_start", dm_start, 1'b0);
        check("t1_busy", busy, 1'b1);
        step();
        check("t2_start", dm_start, 1'b1);
        check("t2_src", dm_src, 32'h1000);
        check("t2_dst", dm_dst, 32'h2000);
        check("t2_len", dm_len, 32'd64);
        step();
        check("t3_start", dm_start, 1'b0);
        check("t3_occ", occupancy, 3'd0);
        dm_done = 1'b1;
        step();
        dm_done = 1'b0;
        check("t1_cpl_valid", cpl_valid, 1'b1);
        check("t1_cpl_id", cpl_id, 4'd3);
        check("t1_cpl_err", cpl_err, 1'b0);
        cpl_ready = 1'b1;
        step();
        cpl_ready = 1'b0;
        check("t1_cpl_drop", cpl_valid, 1'b0);
        check("t1_busy_end", busy, 1'b0);

        // Five jobs with the first stalled in WAIT: FIFO fills, sixth refused.
        s0 = start_cnt;
        c0 = cpl_cnt;
        for (int i = 0; i < 5; i++) begin
            push(32'h100 * i, 32'h8000 + 32'h10 * i, 32'd16 + i, 4'(i));
        end
        check("fill_occ", occupancy, 3'd4);
        check("fill_ready", job_ready, 1'b0);
        push(32'hdead, 32'hbeef, 32'd1, 4'd5);
        check("fill_occ_after", occupancy, 3'd4);
        dm_done = 1'b1;
        step();
        dm_done = 1'b0;
        auto_done = 1'b1;
        cpl_ready = 1'b1;
        wait_idle("fill_drain", 200);
        check("fill_starts", start_cnt - s0, 5);
        check("fill_cpls", cpl_cnt - c0, 5);

        // Zero-length job: completes without a start pulse.
        cpl_ready = 1'b0;
        s0 = start_cnt;
        push(32'h4000, 32'h5000, 32'd0, 4'd7);
        step();
        check("zl_cpl_valid", cpl_valid, 1'b1);
        check("zl_cpl_id", cpl_id, 4'd7);
        check("zl_cpl_err", cpl_err, 1'b0);
        check("zl_no_start", start_cnt - s0, 0);
        cpl_ready = 1'b1;
        wait_idle("zl_idle", 20);

        // Completion back-pressure with two jobs queued behind it.
        cpl_ready = 1'b0;
        push(32'hA000, 32'hA100, 32'd8, 4'd9);
        push(32'hB000, 32'hB100, 32'd8, 4'd10);
        push(32'hC000, 32'hC100, 32'd8, 4'd11);
        wait_cpl("hold_cpl", 30);
        check("hold_occ", occupancy, 3'd2);
        s0 = start_cnt;
        for (int i = 0; i < 10; i++) begin
            check("hold_valid", cpl_valid, 1'b1);
            check("hold_id", cpl_id, 4'd9);
            check("hold_src", dm_src, 32'hA000);
            check("hold_no_start", start_cnt - s0, 0);
            step();
        end
        cpl_ready = 1'b1;
        wait_idle("hold_drain", 100);

        // Clear during WAIT with three jobs queued.
        auto_done = 1'b0;
        push(32'hD000, 32'hD100, 32'd32, 4'd12);
        wait_start("clr_start", 10);
        step();
        push(32'h1, 32'h2, 32'd4, 4'd13);
        push(32'h3, 32'h4, 32'd4, 4'd14);
        push(32'h5, 32'h6, 32'd4, 4'd15);
        check("clr_occ_before", occupancy, 3'd3);
        s0 = start_cnt;
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_occ", occupancy, 3'd0);
        check("clr_busy", busy, 1'b0);
        check("clr_cpl_valid", cpl_valid, 1'b0);
        check("clr_len", dm_len, 32'd0);
        check("clr_ready", job_ready, 1'b1);
        dm_done = 1'b1;
        step();
        dm_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("clr_no_cpl", cpl_valid, 1'b0);
            step();
        end
        check("clr_no_start", start_cnt - s0, 0);

`ifdef DATAMOVER_JOBQ_TIMEOUT_EN
        // Watchdog expiry: completion 16 cycles after entering WAIT, flagged.
        cpl_ready = 1'b0;
        exp_err = 1'b1;
        push(32'hE000, 32'hE100, 32'd16, 4'd2);
        wait_start("to_start", 10);
        step();
        repeat (15) step();
        check("to_not_yet", cpl_valid, 1'b0);
        step();
        check("to_cpl_valid", cpl_valid, 1'b1);
        check("to_cpl_err", cpl_err, 1'b1);
        cpl_ready = 1'b1;
        step();
        cpl_ready = 1'b0;
        exp_err = 1'b0;
        dm_done = 1'b1;
        step();
        dm_done = 1'b0;
        step();
        check("to_late_done", cpl_valid, 1'b0);

        // Done on the final WAIT cycle beats the timeout.
        push(32'hF000, 32'hF100, 32'd16, 4'd4);
        wait_start("to2_start", 10);
        step();
        repeat (15) step();
        dm_done = 1'b1;
        step();
        dm_done = 1'b0;
        check("to2_cpl_valid", cpl_valid, 1'b1);
        check("to2_cpl_err", cpl_err, 1'b0);
        cpl_ready = 1'b1;
        wait_idle("to2_idle", 20);
`endif

        // Randomized traffic against the order-based model.
        auto_done = 1'b1;
        spur_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            job_valid = ($urandom_range(0, 1) == 1);
            job_src = $urandom;
            job_dst = $urandom;
            job_len = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 4096));
            job_id = 4'($urandom_range(0, 15));
            cpl_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        job_valid = 1'b0;
        cpl_ready = 1'b1;
        wait_idle("rnd_drain", 500);
        spur_en = 1'b0;
        repeat (3) step();
        check("rnd_issue_left", issue_q.size(), 0);
        check("rnd_cpl_left", cpl_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/datamover_job_queue.md
Name: datamover_job_queue

Overview:
- Job scheduler in front of the datamover controller: software or a host FSM pushes copy descriptors (src, dst, length, id) into a small FIFO.
- The block issues descriptors one at a time as a registered configuration plus a single-cycle start pulse, then waits for the datamover's done.
- After done, it returns a tagged completion over a valid/ready port.
- Sits between the register-file/control side and the datamover FSM, so several transfers can be queued back to back without per-job core intervention.

Parameters:
- QUEUE_DEPTH, 4: descriptor FIFO entries; power of 2, >= 2.
- AW, 32: address width of src/dst.
- LW, 32: width of transfer length (bytes).
- ID_W, 4: job tag width.
- TIMEOUT_CYCLES, 1024: watchdog limit, used only with the optional feature; >= 2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- clear_i  in  1  synchronous soft clear.
- job_valid_i  in  1  descriptor push valid.
- job_ready_o  out  1  descriptor push ready (FIFO not full).
- job_src_i  in  AW  source base address.
- job_dst_i  in  AW  destination base address.
- job_len_i  in  LW  total length in bytes.
- job_id_i  in  ID_W  job tag.
- dm_start_o  out  1  one-cycle start pulse to the datamover.
- dm_src_o  out  AW  registered source of the in-flight job.
- dm_dst_o  out  AW  registered destination of the in-flight job.
- dm_len_o  out  LW  registered length of the in-flight job.
- dm_done_i  in  1  datamover completion pulse.
- cpl_valid_o  out  1  completion valid.
- cpl_ready_i  in  1  completion ready.
- cpl_id_o  out  ID_W  tag of the completed job.
- cpl_err_o  out  1  completion flagged as timed out.
- busy_o  out  1  job in flight or FIFO non-empty.
- occupancy_o  out  $clog2(QUEUE_DEPTH+1)  FIFO entry count; excludes the in-flight job.

Behaviour:
- Reset: rst_ni is asynchronous, active-low; clock is clk_i. All outputs reset to 0, except job_ready_o, which is 1 once reset is released. FIFO is empty and the FSM is in IDLE.
- Push: a descriptor is accepted when job_valid_i & job_ready_o. job_ready_o = !full.
  - No bypass: when full, job_ready_o stays 0 even in a cycle where the FIFO pops.
  - Push and pop in the same cycle (not full) leaves occupancy unchanged.
- FSM states: IDLE, ISSUE, WAIT, CPL.
- IDLE:
  - If the FIFO is non-empty, pop the head into the job registers (dm_src_o, dm_dst_o, dm_len_o, id).
  - If the popped len != 0, go to ISSUE.
  - If len == 0, go straight to CPL with cpl_err_o = 0; no start pulse is issued.
- ISSUE: dm_start_o = 1 for exactly this cycle, then go to WAIT. dm_done_i is ignored in ISSUE.
- WAIT: on dm_done_i go to CPL with cpl_err_o = 0.
- CPL:
  - cpl_valid_o = 1, with cpl_id_o and cpl_err_o held stable, until cpl_ready_i.
  - On the handshake, go to IDLE.
  - The next pop happens in IDLE, so there are at least 2 cycles between consecutive dm_start_o pulses after a completion handshake.
- dm_src_o, dm_dst_o and dm_len_o stay constant from pop until the next pop.
- Latency: a push at cycle t into an empty queue with the FSM in IDLE gives occupancy_o = 1 at t+1, pop at t+1, and dm_start_o = 1 at t+2.
- busy_o = (state != IDLE) | (occupancy != 0).
- dm_done_i in IDLE or CPL is ignored; it is a spurious pulse.
- clear_i: takes effect at the next edge. Flushes the FIFO, FSM goes to IDLE, and all outputs take their reset values. Any pending completion is dropped. clear_i has priority over push, pop and done in the same cycle.
- FIFO pointers are log2(QUEUE_DEPTH) bits and wrap naturally. A separate occupancy counter distinguishes full from empty.

Optional Feature:
- Macro DATAMOVER_JOBQ_TIMEOUT_EN.
- Defined:
  - A watchdog counter is cleared on entry to WAIT and increments every WAIT cycle.
  - If it reaches TIMEOUT_CYCLES-1 with no dm_done_i, the FSM goes to CPL with cpl_err_o = 1.
  - A dm_done_i in the same cycle as the timeout wins, giving cpl_err_o = 0.
  - A late dm_done_i after a timeout is ignored.
- Undefined: no counter logic exists, WAIT waits indefinitely, and cpl_err_o is tied to 0.

Test Plan:
- Reset, then push one job (src=0x1000, dst=0x2000, len=64, id=3) at cycle t:
  - dm_start_o is high only at t+2, with dm_src_o=0x1000, dm_dst_o=0x2000, dm_len_o=64.
  - After dm_done_i, cpl_valid_o=1 with cpl_id_o=3 and cpl_err_o=0.
  - busy_o=0 after the handshake.
- Push 5 jobs (ids 0-4) with QUEUE_DEPTH=4 while the first is stalled in WAIT:
  - job_ready_o=0 on the 6th attempt (occupancy_o=4).
  - Completions come out in order 0-4, exactly one start pulse per job.
- Push a job with len=0, id=7: no dm_start_o; cpl_valid_o=1, cpl_id_o=7 within 2 cycles of the push.
- Hold cpl_ready_i=0 for 10 cycles with 2 jobs queued:
  - cpl_valid_o, cpl_id_o and dm_* stay stable.
  - No second dm_start_o until the handshake.
- Assert clear_i during WAIT with 3 jobs queued:
  - Next cycle occupancy_o=0, busy_o=0, cpl_valid_o=0.
  - A subsequent dm_done_i produces no completion.
- With DATAMOVER_JOBQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, and no dm_done_i: cpl_valid_o=1 with cpl_err_o=1 exactly 16 cycles after entering WAIT.
  - Repeat with dm_done_i on the 16th WAIT cycle: cpl_err_o=0.
